serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement/unsigned subtractor computing a - b, one bit per clock, LSB first, with a registered borrow.
- It is the inverse-direction counterpart of the team's combinational adder cells: it trades area for latency by reusing one single-bit subtract cell across W cycles.
- It sits between an operand producer and a result consumer, both using valid/ready handshakes.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  W  minuend.
- b  input  W  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  W  (a - b) mod 2^W.
- borrow  output  1  1 when unsigned a < b.
- zero  output  1  1 when diff == 0.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst high at an edge):
  - state goes to IDLE; in_ready=1, out_valid=0, diff=0, borrow=0, zero=0.
  - Internal shift registers, bit counter and borrow flop are all cleared.
  - Reset takes effect in any state, including mid-RUN; the partial result is discarded and no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - Input handshake when in_valid && in_ready at an edge: a and b are captured into shift registers, borrow flop = 0, counter = 0, state goes to RUN.
- RUN:
  - in_ready=0; in_valid, a and b are ignored.
  - Each edge: bit-cell inputs are ai = a_sh[0], bi = b_sh[0], bin = borrow flop.
    - d = ai ^ bi ^ bin
    - bout = (~ai & bi) | (~(ai ^ bi) & bin)
  - d shifts into the MSB end of the result register. a_sh and b_sh shift right. Borrow flop = bout. Counter increments.
  - On the edge where the counter reaches W-1 (the W-th bit):
    - state goes to DONE.
    - diff = the full result.
    - borrow = the final bout.
    - zero = (diff == 0).
    - out_valid = 1 after this edge.
- Latency: with the input handshake at edge t, out_valid is first high in the cycle after edge t+W. For W=1, that is after edge t+1.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, borrow and zero are held stable while out_valid && !out_ready.
  - Output handshake when out_valid && out_ready at an edge: out_valid goes to 0 and state goes to IDLE. in_ready is high in the following cycle.
  - There is no back-to-back overlap: a new operand pair can be accepted no earlier than one cycle after the output handshake. Throughput is 1 result per W+2 cycles.
- diff, borrow and zero change only at RUN completion or on reset. They keep their last values in IDLE.
- Arithmetic:
  - diff equals (a - b) mod 2^W.
  - borrow equals (a < b) unsigned.
  - Signed overflow is not reported.
- Counter width is $clog2(W)+1 bits; the counter never wraps during legal operation.
- X on a or b outside an input handshake must not propagate into the state.

Decomposition:
- Shared package (arith_pkg): state enum type (IDLE, RUN, DONE) and a width-helper constant function for the counter.
- One sub-module, full_subtractor: single-bit combinational cell with inputs a, b, bin and outputs d, bout (equations above). It is instantiated once, inside the RUN datapath.

Test Plan:
- W=8, a=5, b=3, out_ready=1 -> out_valid first high exactly 8 cycles after the in handshake's following edge; diff=8'h02, borrow=0, zero=0.
- W=8, a=3, b=5 -> diff=8'hFE, borrow=1. Then a=8'hA5, b=8'hA5 -> diff=0, borrow=0, zero=1. Also a=0, b=8'hFF -> diff=8'h01, borrow=1.
- Backpressure: complete a=9, b=4 with out_ready=0 for 5 cycles -> out_valid stays 1, diff stays 8'h05, in_ready stays 0. Raise out_ready -> in_ready=1 on the next cycle.
- In_valid held high with new operands during RUN -> ignored; result matches only the first captured pair. The second pair is accepted only after the return to IDLE.
- Reset mid-RUN (rst at the 4th RUN cycle) -> next cycle: in_ready=1, out_valid=0, diff=0, borrow=0. The following transaction a=7, b=2 gives diff=8'h05 with no residue from the aborted one.
- W=4 and W=1 exhaustive sweep of all a, b pairs against a golden model of (a-b) mod 2^W and a<b -> every result matches, and latency equals W.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: the sequencer state
// encoding and a helper that sizes the per-bit counter.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One spare bit above $clog2 keeps the counter from wrapping, even when W is a power of two.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit combinational subtract cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, reusing a single subtract
// cell and a borrow flop; valid/ready handshakes on both sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t        r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_res;
    logic          r_bflop;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_diff;
    logic          r_borrow;
    logic          r_zero;

    logic          w_d;
    logic          w_bout;
    logic [W-1:0]  w_res_next;

    full_subtractor u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_bflop),
        .d    (w_d),
        .bout (w_bout)
    );

    // New bit enters at the MSB end so the LSB-first result lands in place after W shifts.
    generate
        if (W == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[W-1:1]};
        end
    endgenerate

    // Sequencer, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= {W{1'b0}};
            r_b_sh      <= {W{1'b0}};
            r_res       <= {W{1'b0}};
            r_bflop     <= 1'b0;
            r_cnt       <= CNT_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_diff      <= {W{1'b0}};
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_res      <= {W{1'b0}};
                        r_bflop    <= 1'b0;
                        r_cnt      <= CNT_ZERO;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_res   <= w_res_next;
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_diff      <= w_res_next;
                        r_borrow    <= w_bout;
                        r_zero      <= (w_res_next == {W{1'b0}});
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state     <= RUN;
                    end
                end
                DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state     <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: W=8 directed scenarios plus W=4 and W=1
// exhaustive sweeps, all checked against a scoreboard of golden results.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // W = 8 instance
    logic       v8 = 1'b0, r8 = 1'b1;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       in_ready8, out_valid8, borrow8, zero8;
    logic [7:0] diff8;

    // W = 4 instance
    logic       v4 = 1'b0, r4 = 1'b1;
    logic [3:0] a4 = 4'd0, b4 = 4'd0;
    logic       in_ready4, out_valid4, borrow4, zero4;
    logic [3:0] diff4;

    // W = 1 instance
    logic       v1 = 1'b0, r1 = 1'b1;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       in_ready1, out_valid1, borrow1, zero1;
    logic [0:0] diff1;

    serial_subtractor #(.W(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(r8), .diff(diff8), .borrow(borrow8), .zero(zero8)
    );
    serial_subtractor #(.W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(r4), .diff(diff4), .borrow(borrow4), .zero(zero4)
    );
    serial_subtractor #(.W(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(r1), .diff(diff1), .borrow(borrow1), .zero(zero1)
    );

    typedef struct packed { logic [7:0] d; logic b; logic z; } exp8_t;
    typedef struct packed { logic [3:0] d; logic b; logic z; } exp4_t;
    typedef struct packed { logic [0:0] d; logic b; logic z; } exp1_t;
    exp8_t q8[$];
    exp4_t q4[$];
    exp1_t q1[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int t;
        exp8_t e;
        t = 0;
        while (in_ready8 !== 1'b1 && t < 100) begin step(); t++; end
        n_checks++;
        if (in_ready8 !== 1'b1) begin
            $display("FAIL send8_ready actual=%b required=1", in_ready8);
            n_errors++;
        end
        e.d = a - b;
        e.b = (a < b);
        e.z = (e.d == 8'd0);
        q8.push_back(e);
        a8 = a; b8 = b; v8 = 1'b1;
        step();
        if (!hold) v8 = 1'b0;
    endtask

    task automatic recv8(input bit check_lat);
        int lat;
        exp8_t e;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 100) begin
            n_checks++;
            if (in_ready8 !== 1'b0) begin
                $display("FAIL run_in_ready actual=%b required=0", in_ready8);
                n_errors++;
            end
            step(); lat++;
        end
        n_checks++;
        if (out_valid8 !== 1'b1) begin
            $display("FAIL recv8_timeout out_valid actual=%b required=1", out_valid8);
            n_errors++;
        end
        if (check_lat) begin
            n_checks++;
            if (lat !== 8) begin
                $display("FAIL latency8 actual=%0d required=8", lat);
                n_errors++;
            end
        end
        n_checks++;
        if (q8.size() == 0) begin
            $display("FAIL scoreboard8_empty actual=0 required=1 entry");
            n_errors++;
        end else begin
            e = q8.pop_front();
            if ({diff8, borrow8, zero8} !== {e.d, e.b, e.z}) begin
                $display("FAIL result8 actual diff=%h borrow=%b zero=%b required diff=%h borrow=%b zero=%b",
                         diff8, borrow8, zero8, e.d, e.b, e.z);
                n_errors++;
            end
        end
        if (r8) begin
            step();
            n_checks++;
            if ({out_valid8, in_ready8} !== 2'b01) begin
                $display("FAIL post_handshake actual out_valid=%b in_ready=%b required 0/1", out_valid8, in_ready8);
                n_errors++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++;
        if ({in_ready8, out_valid8, diff8, borrow8, zero8} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state actual in_ready=%b out_valid=%b diff=%h borrow=%b zero=%b required 1/0/00/0/0",
                     in_ready8, out_valid8, diff8, borrow8, zero8);
            n_errors++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        send8(8'd5, 8'd3, 1'b0);    recv8(1'b1);
        send8(8'd3, 8'd5, 1'b0);    recv8(1'b1);
        send8(8'hA5, 8'hA5, 1'b0);  recv8(1'b1);
        send8(8'h00, 8'hFF, 1'b0);  recv8(1'b1);
        send8(8'hFF, 8'h00, 1'b0);  recv8(1'b1);
        send8(8'h80, 8'h01, 1'b0);  recv8(1'b1);
    endtask

    task automatic test_backpressure();
        r8 = 1'b0;
        send8(8'd9, 8'd4, 1'b0);
        recv8(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({out_valid8, in_ready8, diff8} !== {1'b1, 1'b0, 8'h05}) begin
                $display("FAIL backpressure_hold cyc=%0d actual out_valid=%b in_ready=%b diff=%h required 1/0/05",
                         i, out_valid8, in_ready8, diff8);
                n_errors++;
            end
        end
        r8 = 1'b1;
        step();
        n_checks++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            $display("FAIL backpressure_release actual out_valid=%b in_ready=%b required 0/1", out_valid8, in_ready8);
            n_errors++;
        end
    endtask

    task automatic test_hold_valid();
        exp8_t e;
        send8(8'd20, 8'd6, 1'b1);
        a8 = 8'd100; b8 = 8'd1;
        recv8(1'b1);
        e.d = 8'd99; e.b = 1'b0; e.z = 1'b0;
        q8.push_back(e);
        step();
        v8 = 1'b0;
        recv8(1'b1);
    endtask

    task automatic test_reset_mid_run();
        send8(8'd50, 8'd3, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(q8.pop_back());
        n_checks++;
        if ({in_ready8, out_valid8, diff8, borrow8} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL reset_mid_run actual in_ready=%b out_valid=%b diff=%h borrow=%b required 1/0/00/0",
                     in_ready8, out_valid8, diff8, borrow8);
            n_errors++;
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (out_valid8 !== 1'b0) begin
                $display("FAIL aborted_output actual out_valid=%b required 0", out_valid8);
                n_errors++;
            end
        end
        send8(8'd7, 8'd2, 1'b0);
        recv8(1'b1);
    endtask

    task automatic test_sweep4();
        exp4_t e;
        int t, lat;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                t = 0;
                while (in_ready4 !== 1'b1 && t < 100) begin step(); t++; end
                a4 = i[3:0]; b4 = j[3:0]; v4 = 1'b1;
                e.d = a4 - b4; e.b = (i < j); e.z = (e.d == 4'd0);
                q4.push_back(e);
                step();
                v4 = 1'b0;
                lat = 0;
                while (out_valid4 !== 1'b1 && lat < 100) begin step(); lat++; end
                e = q4.pop_front();
                n_checks++;
                if ({out_valid4, diff4, borrow4, zero4} !== {1'b1, e.d, e.b, e.z} || lat !== 4) begin
                    $display("FAIL sweep4 a=%0d b=%0d actual v=%b diff=%h borrow=%b zero=%b lat=%0d required diff=%h borrow=%b zero=%b lat=4",
                             i, j, out_valid4, diff4, borrow4, zero4, lat, e.d, e.b, e.z);
                    n_errors++;
                end
                step();
            end
        end
    endtask

    task automatic test_sweep1();
        exp1_t e;
        int t, lat;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                t = 0;
                while (in_ready1 !== 1'b1 && t < 100) begin step(); t++; end
                a1 = i[0:0]; b1 = j[0:0]; v1 = 1'b1;
                e.d = a1 - b1; e.b = (i < j); e.z = (e.d == 1'b0);
                q1.push_back(e);
                step();
                v1 = 1'b0;
                lat = 0;
                while (out_valid1 !== 1'b1 && lat < 100) begin step(); lat++; end
                e = q1.pop_front();
                n_checks++;
                if ({out_valid1, diff1, borrow1, zero1} !== {1'b1, e.d, e.b, e.z} || lat !== 1) begin
                    $display("FAIL sweep1 a=%0d b=%0d actual v=%b diff=%b borrow=%b zero=%b lat=%0d required diff=%b borrow=%b zero=%b lat=1",
                             i, j, out_valid1, diff1, borrow1, zero1, lat, e.d, e.b, e.z);
                    n_errors++;
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_hold_valid();
        test_reset_mid_run();
        test_sweep4();
        test_sweep1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
